prio_arb_rr: RTL
================

Name: prio_arb_rr

Overview:
- Parametrised successor to the fixed 4-input registered priority encoder.
- Arbitrates N request lines into a registered grant: binary index, one-hot vector and valid flag.
- Mode is selectable at run time: fixed priority (index 0 highest) or round-robin.
- Adds a valid/ready handshake so a grant is held stable until the consumer accepts it. Sits in front of shared resources, e.g. a bus or memory port.

Parameters:
- N, 8, number of requesters; legal range 2..32
- IDX_W, $clog2(N), width of the binary grant index (derived, do not override)
- CNT_W, 16, width of the grant counter (used only with ARB_STATS_EN)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N  request vector; bit i = requester i
- mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin
- ready  in  1  consumer accepts current grant this cycle
- Y  out  IDX_W  registered index of granted requester
- gnt  out  N  registered one-hot grant; all zeros when valid=0
- valid  out  1  grant present
- grant_cnt  out  CNT_W  accepted-grant count (present only with ARB_STATS_EN)

Behaviour:
- Reset (rst_n=0, takes effect asynchronously without a clock edge): Y=0, gnt=0, valid=0, rr_ptr=0, grant_cnt=0.
- State is held in valid; two states:
  - IDLE (valid=0)
  - GRANT (valid=1)
- Arbitration point = any rising edge where valid=0, or where valid=1 and ready=1.
- At an arbitration point:
  - req != 0: winner registered into Y/gnt, valid=1.
  - req == 0: valid=0, gnt=0, Y keeps its last value.
- Latency: req to grant is 1 clock. Back-to-back accepts with req nonzero keep valid=1 continuously, with a new winner every cycle.
- Hold: while valid=1 and ready=0, Y/gnt/valid are frozen, even if req changes or the granted bit drops. No re-arbitration and no pointer update.
- Fixed mode: winner = lowest set index of req.
- Round-robin mode: winner = first set index searching rr_ptr, rr_ptr+1, ..., N-1, 0, ..., rr_ptr-1.
- rr_ptr update:
  - Advances only on acceptance (valid=1, ready=1): rr_ptr <= (Y+1) mod N.
  - Wrap: Y=N-1 gives rr_ptr=0.
  - Also updated on acceptances made in fixed mode, so a switch to round-robin starts after the last winner.
- mode is sampled only at arbitration points; changing it during a hold has no effect until acceptance.
- gnt is always exactly onehot(Y) when valid=1.
- Reset asserted mid-grant: outputs and pointer clear immediately. The first arbitration after release uses rr_ptr=0.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Port grant_cnt exists.
  - Increments by 1 on every edge with valid=1 and ready=1.
  - Saturates at 2^CNT_W-1, never wraps.
  - Cleared by reset only.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: rst_n=0 with req=8'hFF, mode=1, mid-cycle -> Y=0, gnt=0, valid=0 immediately (before the next edge). Outputs stay 0 while rst_n=0.
- Fixed priority:
  - mode=0, ready=1, req=8'b1010_0100 -> after 1 edge: Y=2, gnt=8'h04, valid=1.
  - Then req=0 -> after next edge: valid=0, gnt=0.
- Hold:
  - mode=0, req=8'h06, ready=0 -> Y=1, gnt=8'h02.
  - Change req to 8'h04 for 3 cycles -> Y stays 1, gnt stays 8'h02.
  - ready=1 for 1 cycle -> next edge: Y=2.
- Round-robin sweep: mode=1, req=8'hFF, ready=1 for 9 cycles -> Y sequence 0,1,2,3,4,5,6,7,0 with valid constantly 1.
- Round-robin skip/wrap:
  - After an accepted grant to 2 (rr_ptr=3), req=8'h05, ready=1 -> Y=0.
  - Then next edge -> Y=2.
  - Then next edge -> Y=0.
- Reset mid-grant plus stats (ARB_STATS_EN, CNT_W=2):
  - mode=1, req=8'hFF, ready=1 for 5 accepts -> grant_cnt=3 (saturated).
  - Hold at Y=5 with ready=0, pulse rst_n low -> valid=0, grant_cnt=0 at once.
  - After release, first grant: Y=0.

Source files
------------

// File: rtl/prio_arb_rr.sv
// N-input arbiter with run-time fixed/round-robin mode and a valid/ready held grant.
// Optional accepted-grant counter enabled by defining ARB_STATS_EN.
module prio_arb_rr #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             mode,
  input  logic             ready,
  output logic [IDX_W-1:0] Y,
  output logic [N-1:0]     gnt,
  output logic             valid
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] y_d;
  logic [N-1:0]     gnt_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] search_base;
  logic [IDX_W-1:0] winner;
  logic             win_found;
  logic             accept;
  logic             arb_point;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(N - 1)) return '0;
    return idx + 1'b1;
  endfunction

  assign valid     = (state_q == GRANT);
  assign accept    = valid && ready;
  assign arb_point = !valid || ready;

  // The pointer moves in the same edge as the new arbitration, so the
  // search must already start from the post-acceptance pointer.
  assign rr_ptr_d    = accept ? next_idx(Y) : rr_ptr_q;
  assign search_base = mode ? rr_ptr_d : '0;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // any path that leaves one unassigned would infer a latch.
    winner    = '0;
    win_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(search_base) + k;
      if (j >= N) j = j - N;
      if (!win_found && req[j]) begin
        winner    = IDX_W'(j);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = Y;
    gnt_d   = gnt;
    if (arb_point) begin
      if (win_found) begin
        state_d = GRANT;
        y_d     = winner;
        gnt_d   = N'(1) << winner;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      Y        <= '0;
      gnt      <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      Y        <= y_d;
      gnt      <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (accept && (grant_cnt != {CNT_W{1'b1}})) begin
      grant_cnt <= grant_cnt + 1'b1;
    end
  end
`endif

endmodule
